// File: rtl/reg_wb_arbiter_pkg.sv
// Shared sizing defaults, grant indices and the zero-register constant for the writeback arbiter slice.
package reg_wb_arbiter_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int REG_UNITS     = 1 << WB_ADDR_WIDTH;

  // Register x0 is hardwired: never written, never reserved.
  localparam int ZERO_REG = 0;

  typedef enum logic {
    GNT_ALU  = 1'b0,
    GNT_LOAD = 1'b1
  } gnt_t;

  function automatic int reg_units(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback request, reservation/hazard query and register-file command bundle.
interface reg_wb_arbiter_if
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;

  logic                  rsv_valid;
  logic [ADDR_WIDTH-1:0] rsv_addr;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic                  busy1;
  logic                  busy2;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output rsv_valid, rsv_addr, raddr1, raddr2,
    input  busy1, busy2,
    input  rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  rsv_valid, rsv_addr, raddr1, raddr2,
    output busy1, busy2,
    output rf_wen, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/reg_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by decode reservations, cleared by writebacks.
// Latency: set/clear visible on the query ports the cycle after the edge; no backpressure.
// Backpressure: none, every set/clear is absorbed in the cycle it is presented.
module wb_scoreboard
  import reg_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] qaddr1,
  input  logic [ADDR_WIDTH-1:0] qaddr2,
  output logic                  qbusy1,
  output logic                  qbusy2
);

  localparam int UNITS = reg_units(ADDR_WIDTH);

  logic [UNITS-1:0] busy_q;
  logic [UNITS-1:0] busy_nxt;

  // Set is applied after clear: a fresh reservation belongs to a newer producer.
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) begin
      busy_nxt[clr_addr] = 1'b0;
    end
    if (set_en) begin
      busy_nxt[set_addr] = 1'b1;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign qbusy1 = busy_q[qaddr1];
  assign qbusy2 = busy_q[qaddr2];

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates ALU (req0) and load (req1) writebacks onto the single register-file write port; tracks RAW hazards.
// Latency: handshake edge -> rf_wen high for one cycle; ready is combinational, one grant per cycle.
// Backpressure: only the arbitration loser sees ready low; round-robin if WB_RR_ARB_EN, else req0 fixed priority.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  reg_wb_arbiter_if.slave bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_cmd_t;

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  wb_cmd_t req0_cmd;
  wb_cmd_t req1_cmd;
  wb_cmd_t gnt_cmd;
  wb_cmd_t rf_cmd;
  logic    rf_wen_q;
  logic    prefer0;
  logic    gnt0;
  logic    gnt1;
  logic    gnt_any;
  logic    gnt_wr;
  logic    sb_busy1;
  logic    sb_busy2;

`ifdef WB_RR_ARB_EN
  gnt_t last_grant;

  // Reset value GNT_LOAD hands the first conflict to the ALU path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GNT_LOAD;
    end else if (gnt0) begin
      last_grant <= GNT_ALU;
    end else if (gnt1) begin
      last_grant <= GNT_LOAD;
    end
  end

  assign prefer0 = (last_grant == GNT_LOAD);
`else
  assign prefer0 = 1'b1;
`endif

  assign req0_cmd = '{addr: bus.req0_addr, data: bus.req0_data};
  assign req1_cmd = '{addr: bus.req1_addr, data: bus.req1_data};

  // Gating with rst keeps both readies low for the whole reset window.
  assign gnt0    = rst & bus.req0_valid & (~bus.req1_valid | prefer0);
  assign gnt1    = rst & bus.req1_valid & ~gnt0;
  assign gnt_any = gnt0 | gnt1;
  assign gnt_cmd = gnt1 ? req1_cmd : req0_cmd;
  assign gnt_wr  = gnt_any & (gnt_cmd.addr != ZERO_ADDR);

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen_q <= 1'b0;
      rf_cmd   <= '0;
    end else begin
      rf_wen_q <= gnt_wr;
      if (gnt_any) begin
        rf_cmd <= gnt_cmd;
      end
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_waddr = rf_cmd.addr;
  assign bus.rf_wdata = rf_cmd.data;

  wb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.rsv_valid),
    .set_addr (bus.rsv_addr),
    .clr_en   (gnt_wr),
    .clr_addr (gnt_cmd.addr),
    .qaddr1   (bus.raddr1),
    .qaddr2   (bus.raddr2),
    .qbusy1   (sb_busy1),
    .qbusy2   (sb_busy2)
  );

  // The output-stage match covers the cycle between scoreboard clear and the actual RF write.
  assign bus.busy1 = sb_busy1 |
                     (rf_wen_q & (rf_cmd.addr == bus.raddr1) & (bus.raddr1 != ZERO_ADDR));
  assign bus.busy2 = sb_busy2 |
                     (rf_wen_q & (rf_cmd.addr == bus.raddr2) & (bus.raddr2 != ZERO_ADDR));

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback producers: req0 is the ALU/execute path, req1 is the load/memory path.
- Drives a registered write command (wen/waddr/wdata) into the register file.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- Sits between the execute/memory stages and the register file in the multi-cycle/pipelined core.

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width; REG_UNITS = 1 << ADDR_WIDTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  ALU writeback request.
- req0_ready  out  1  req0 accepted this cycle.
- req0_addr  in  ADDR_WIDTH  destination register.
- req0_data  in  DATA_WIDTH  write data.
- req1_valid, req1_ready, req1_addr, req1_data: same as req0, for the load path.
- rsv_valid  in  1  decode reserves a destination register.
- rsv_addr  in  ADDR_WIDTH  register being reserved.
- raddr1, raddr2  in  ADDR_WIDTH  decode source-register queries.
- busy1, busy2  out  1  source register has a pending write.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_WIDTH  register-file write address (registered).
- rf_wdata  out  DATA_WIDTH  register-file write data (registered).

Behaviour:
- Reset (rst=0, async): rf_wen=0, rf_waddr=0, rf_wdata=0; all busy bits=0; last_grant=1, so req0 wins the first conflict. req*_ready are combinational and therefore 0 during reset.
- Handshake:
  - Transfer occurs when valid & ready are both high at a posedge.
  - The output stage drains every cycle, so at most one grant per cycle and no backpressure beyond arbitration.
  - ready may depend combinationally on either valid; producers must not make valid depend on ready.
  - A producer holds valid/addr/data stable until ready.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid: grant the requester that is not last_grant; the loser keeps valid and is granted next cycle.
  - last_grant <= granted index on every grant.
- Output stage:
  - On a grant, at the next posedge: rf_wen <= (addr != 0), rf_waddr <= addr, rf_wdata <= data.
  - No grant: rf_wen <= 0; rf_waddr/rf_wdata hold their values.
  - Write latency: handshake edge → rf_wen high for exactly 1 cycle → register file updated at the following edge.
  - addr 0: the request is accepted and consumed, but rf_wen stays 0 and the scoreboard is untouched.
- Scoreboard (busy[REG_UNITS]):
  - rsv_valid & rsv_addr!=0 sets busy[rsv_addr].
  - A write handshake clears busy[addr].
  - Set and clear of the same register in one cycle: set wins (a newer producer owns it).
  - Reserving an already-busy register: it stays busy. Single bit, no count; producers write back in program order.
  - busy[0] is always 0.
- Hazard query:
  - busyN = busy[raddrN] | (rf_wen & rf_waddr == raddrN & raddrN != 0).
  - This covers the cycle where the scoreboard bit is cleared but the register file is not yet written.
  - busyN is combinational from registered state and the raddr inputs.
- Reset mid-operation: in-flight output write dropped (rf_wen=0 immediately), all reservations discarded, ready low while rst=0.

Optional Feature:
- Macro WB_RR_ARB_EN.
- Defined: round-robin arbitration via last_grant, as above.
- Undefined: fixed priority, req0 always wins conflicts and req1 waits. last_grant is not implemented. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - DATA_WIDTH/ADDR_WIDTH defaults.
  - REG_UNITS.
  - Grant index constants GNT_ALU=0, GNT_LOAD=1.
  - Zero-register address constant.
- One natural sub-module: wb_scoreboard (busy vector, set/clear priority, two query ports). Arbiter and output stage stay in the top module.

Test Plan:
- Reset then req0 valid, addr=5, data=0xDEADBEEF → req0_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, rf_wen=0.
- Both valid continuously (req0 addr=3, req1 addr=4) with WB_RR_ARB_EN → grants alternate 0,1,0,1; rf_waddr sequence 3,4,3,4. Without the macro → req0 granted every cycle, req1_ready stays 0.
- rsv addr=7, then raddr1=7 → busy1=1 until the handshake. Cycle after the handshake: busy1=1 via the output-stage match. Following cycle: busy1=0.
- Same cycle: rsv addr=9 and write handshake to addr 9 → busy[9] remains 1.
- req1 write to addr 0 with data 0xFFFFFFFF → req1_ready=1, rf_wen stays 0; rsv_addr=0 → busy1=0 for raddr1=0.
- Assert rst low while rf_wen=1 and busy[2]=1 → rf_wen drops immediately, busy2=0 for raddr2=2, and after release req0 wins the first conflict.
